rf_wb_sched: RTL and testbench
==============================

// Module: rf_wb_sched
// PURPOSE
//  Schedules all register-file writes for the ARM32 core onto a single RF write port, and
//  interlocks issue against pending writes with a per-register scoreboard.
//  Decode can request two writes per instruction: slot 1 is Rd or r14, slot 2 is the base
//  writeback Rn. The issue stage asks permission here. Execute/memory retire their write
//  pairs here. This block serialises each pair into one write per cycle.
// PARAMETERS
//  NREGS   16  number of architectural registers (index width 4)
//  DW      32  RF data width
//  CNT_W   2   width of per-register pending-write counter
// PORTS
//  clk        in   1      core clock
//  rst        in   1      asynchronous reset, active high
//  iss_valid  in   1      issue stage presents an instruction
//  iss_ready  out  1      instruction may issue (hazard-free, scoreboard has room)
//  iss_rs     in   12     {rs3,rs2,rs1} read indices
//  iss_rs_use in   3      per-operand "actually read" mask
//  iss_ws1    in   4      slot-1 write index;  iss_we1 in 1  slot-1 write enable
//  iss_ws2    in   4      slot-2 write index;  iss_we2 in 1  slot-2 write enable
//  wb_valid   in   1      retirement write pair presented
//  wb_ready   out  1      pair accepted this cycle when wb_valid&wb_ready
//  wb_ws1     in   4;  wb_we1 in 1;  wb_d1 in DW   slot-1 write
//  wb_ws2     in   4;  wb_we2 in 1;  wb_d2 in DW   slot-2 write
//  rf_we      out  1      RF write strobe
//  rf_wa      out  4      RF write address
//  rf_wd      out  DW     RF write data
// BEHAVIOUR
//  Reset (async): state=IDLE, all counters=0, latched pair cleared, rf_we=0, rf_wa=0, rf_wd=0.
//   iss_ready=0 while rst is high. wb_ready=1 from the first cycle after release.
//  FSM IDLE/W1/W2. The pair is latched on a wb handshake.
//   Next state: W1 if we1; else W2 if we2; else IDLE (no writes, pair is dropped).
//   W1: rf_we=1, rf_wa=ws1, rf_wd=d1. Next state is W2 if we2, else final.
//   W2: rf_we=1, rf_wa=ws2, rf_wd=d2. Next state is final.
//   wb_ready=1 in IDLE and in the final write state (W1 with !we2, or W2).
//   Final: on a new accept, go to W1/W2 per the new pair. Otherwise go to IDLE.
//   Latency: accept in cycle N gives slot 1 in N+1 and slot 2 in N+2.
//   Sustained throughput is one single-write pair per cycle.
//  Order: slot 1 is always written before slot 2. If ws1==ws2, the slot-2 value wins.
//  Scoreboard: one CNT_W counter per register.
//   Issue handshake: +1 on ws1 if we1, and +1 on ws2 if we2. Same index in both slots gives +2.
//   rf_we cycle: -1 on rf_wa.
//   Increment and decrement in the same cycle on the same register: net change is the sum.
//  iss_ready = !rst & no hazard & no overflow.
//   Hazard: any used rs with counter != 0.
//   Overflow: any enabled ws whose counter plus its increment would exceed 2^CNT_W-1.
//  A decrement on a zero counter is an error. The counter stays at 0 and an assertion fires.
//  wb writes arrive in issue order. This block does no reordering.
//  Reset mid-pair: the pending slot is abandoned and no further rf_we occurs.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: the hazard check uses post-decrement counters.
//   A reader whose last pending write is on rf_we this cycle may issue in the same cycle.
//   The RF must be write-before-read.
//  RF_WB_BYPASS_EN undefined: the hazard check uses registered counters only.
//   Such a reader issues one cycle later.
// STRUCTURE
//  arm32_base.v holds shared constants: register indices (r14, r15), true/false, and the
//   FSM state encodings ST_IDLE/ST_W1/ST_W2.
//  Sub-module rf_scoreboard holds the counter array, inc/dec merge, and the hazard/overflow
//   check (the bypass macro is applied here).
//  The top level contains the FSM, the pair latch and the RF port muxing.
// TESTING
//  1. Single write: issue ws1=3 we1; wb ws1=3 d1=0xA5 -> rf_we=1 wa=3 wd=0xA5 at N+1; cnt[3] 1->0.
//  2. LDR writeback: wb we1 ws1=2 d1=0x10, we2 ws2=5 d2=0x20 -> wa=2 at N+1, wa=5 at N+2;
//     wb_ready=0 at N+1, 1 at N+2.
//  3. RAW stall: issue writes r4; next instr reads r4 -> iss_ready=0 until r4 is written.
//     Resumes in the same cycle with bypass, one cycle later without.
//  4. Overflow: three unretired writes to r1 -> a 4th issue writing r1 holds iss_ready=0
//     until one retires.
//  5. Back-to-back: wb pairs with only we1, presented every cycle -> rf_we=1 every cycle,
//     wb_ready stays 1.
//  6. Reset mid-pair: assert rst in W1 of a two-write pair -> no W2 write, counters=0,
//     wb_ready=1 after release.

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// Shared constants and types for the RF write-back scheduler.
// Holds register indices, widths, FSM state encodings and counter helpers.
package rf_wb_sched_pkg;

   localparam int NREGS = 16;
   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int CNT_W = 2;

   localparam logic [AW-1:0] REG_R14 = 4'd14;
   localparam logic [AW-1:0] REG_R15 = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_W1   = 2'd1,
      ST_W2   = 2'd2
   } st_e;

   typedef struct packed {
      logic [AW-1:0] ws;
      logic          we;
      logic [DW-1:0] d;
   } slot_t;

   // Merged counter update; a decrement of an empty counter is dropped.
   function automatic logic [CNT_W-1:0] cnt_next(
      input logic [CNT_W-1:0] cnt,
      input logic [1:0]       inc,
      input logic             dec
   );
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + (CNT_W+1)'(inc);
      if (dec && cnt != '0)
         sum = sum - (CNT_W+1)'(1);
      return CNT_W'(sum);
   endfunction

endpackage

// File: rtl/rf_wb_sched_if.sv
// Issue / retirement / RF-port bundle of the write-back scheduler.
// master drives requests and write pairs, slave is the scheduler.
interface rf_wb_sched_if;
   import rf_wb_sched_pkg::*;

   logic            iss_valid;
   logic            iss_ready;
   logic [3*AW-1:0] iss_rs;
   logic [2:0]      iss_rs_use;
   logic [AW-1:0]   iss_ws1;
   logic            iss_we1;
   logic [AW-1:0]   iss_ws2;
   logic            iss_we2;

   logic            wb_valid;
   logic            wb_ready;
   logic [AW-1:0]   wb_ws1;
   logic            wb_we1;
   logic [DW-1:0]   wb_d1;
   logic [AW-1:0]   wb_ws2;
   logic            wb_we2;
   logic [DW-1:0]   wb_d2;

   logic            rf_we;
   logic [AW-1:0]   rf_wa;
   logic [DW-1:0]   rf_wd;

   modport master (
      output iss_valid, iss_rs, iss_rs_use,
      output iss_ws1, iss_we1, iss_ws2, iss_we2,
      output wb_valid, wb_ws1, wb_we1, wb_d1,
      output wb_ws2, wb_we2, wb_d2,
      input  iss_ready, wb_ready,
      input  rf_we, rf_wa, rf_wd
   );

   modport slave (
      input  iss_valid, iss_rs, iss_rs_use,
      input  iss_ws1, iss_we1, iss_ws2, iss_we2,
      input  wb_valid, wb_ws1, wb_we1, wb_d1,
      input  wb_ws2, wb_we2, wb_d2,
      output iss_ready, wb_ready,
      output rf_we, rf_wa, rf_wd
   );

endinterface

// File: rtl/rf_wb_sched_scoreboard.sv
// Per-register pending-write counters with issue hazard/overflow check.
// RF_WB_BYPASS_EN: hazard check sees counters after this cycle's RF write.
module rf_wb_sched_scoreboard
   import rf_wb_sched_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_fire,
   input  logic [AW-1:0]   i_ws1,
   input  logic            i_we1,
   input  logic [AW-1:0]   i_ws2,
   input  logic            i_we2,
   input  logic [3*AW-1:0] i_rs,
   input  logic [2:0]      i_rs_use,
   input  logic            i_dec_en,
   input  logic [AW-1:0]   i_dec_a,
   output logic            o_ok
);

   localparam logic [CNT_W:0] CNT_LIM = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] r_cnt [NREGS];
   logic [CNT_W-1:0] w_nxt [NREGS];
   logic [CNT_W-1:0] w_rd  [NREGS];
   logic [1:0]       w_inc [NREGS];
   logic             w_dec [NREGS];
   logic [CNT_W:0]   w_add1;
   logic [CNT_W:0]   w_add2;
   logic             w_hazard;
   logic             w_ovf;

   // Per-register increment/decrement merge and hazard-view counters.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         w_inc[i] = 2'(i_fire & i_we1 & (i_ws1 == AW'(i)))
                  + 2'(i_fire & i_we2 & (i_ws2 == AW'(i)));
         w_dec[i] = i_dec_en & (i_dec_a == AW'(i));
         w_nxt[i] = cnt_next(r_cnt[i], w_inc[i], w_dec[i]);
`ifdef RF_WB_BYPASS_EN
         w_rd[i]  = cnt_next(r_cnt[i], 2'b00, w_dec[i]);
`else
         w_rd[i]  = r_cnt[i];
`endif
      end
   end

   // Read-after-write hazard and counter-saturation check for the candidate.
   always_comb begin
      w_hazard = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (i_rs_use[k] && w_rd[i_rs[AW*k +: AW]] != '0)
            w_hazard = 1'b1;
      end
      w_add1 = (CNT_W+1)'(1)
             + (CNT_W+1)'(i_we2 && (i_ws2 == i_ws1));
      w_add2 = (CNT_W+1)'(1)
             + (CNT_W+1)'(i_we1 && (i_ws1 == i_ws2));
      w_ovf  = (i_we1 && (({1'b0, r_cnt[i_ws1]} + w_add1) > CNT_LIM))
            || (i_we2 && (({1'b0, r_cnt[i_ws2]} + w_add2) > CNT_LIM));
      o_ok   = !w_hazard && !w_ovf;
   end

   // Counter array update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            r_cnt[i] <= w_nxt[i];
      end
   end

   a_dec_nonzero: assert property (
      @(posedge clk) disable iff (rst)
      !(i_dec_en && r_cnt[i_dec_a] == '0)
   );

endmodule

// File: rtl/rf_wb_sched.sv
// Serialises retirement write pairs onto one RF write port and gates issue.
// RF_WB_BYPASS_EN (in scoreboard): same-cycle reader release on RF write.
module rf_wb_sched
   import rf_wb_sched_pkg::*;
(
   input logic            clk,
   input logic            rst,
   rf_wb_sched_if.slave   io_bus
);

   st_e           r_state;
   slot_t         r_slot2;
   logic          r_rf_we;
   logic [AW-1:0] r_rf_wa;
   logic [DW-1:0] r_rf_wd;
   logic          r_wb_ready;

   logic          w_ok;
   logic          w_fire;
   logic          w_accept;

   assign io_bus.iss_ready = !rst && w_ok;
   assign io_bus.wb_ready  = r_wb_ready;
   assign io_bus.rf_we     = r_rf_we;
   assign io_bus.rf_wa     = r_rf_wa;
   assign io_bus.rf_wd     = r_rf_wd;

   assign w_fire   = io_bus.iss_valid && !rst && w_ok;
   assign w_accept = io_bus.wb_valid && r_wb_ready;

   rf_wb_sched_scoreboard u_sb (
      .clk      (clk),
      .rst      (rst),
      .i_fire   (w_fire),
      .i_ws1    (io_bus.iss_ws1),
      .i_we1    (io_bus.iss_we1),
      .i_ws2    (io_bus.iss_ws2),
      .i_we2    (io_bus.iss_we2),
      .i_rs     (io_bus.iss_rs),
      .i_rs_use (io_bus.iss_rs_use),
      .i_dec_en (r_rf_we),
      .i_dec_a  (r_rf_wa),
      .o_ok     (w_ok)
   );

   // Write FSM: latch pair, emit slot 1 then slot 2, registered RF port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_slot2    <= '0;
         r_rf_we    <= 1'b0;
         r_rf_wa    <= '0;
         r_rf_wd    <= '0;
         r_wb_ready <= 1'b1;
      end else if (r_state == ST_W1 && r_slot2.we) begin
         r_state    <= ST_W2;
         r_rf_we    <= 1'b1;
         r_rf_wa    <= r_slot2.ws;
         r_rf_wd    <= r_slot2.d;
         r_wb_ready <= 1'b1;
      end else if (w_accept) begin
         r_slot2 <= '{ws: io_bus.wb_ws2,
                      we: io_bus.wb_we2,
                      d:  io_bus.wb_d2};
         if (io_bus.wb_we1) begin
            r_state    <= ST_W1;
            r_rf_we    <= 1'b1;
            r_rf_wa    <= io_bus.wb_ws1;
            r_rf_wd    <= io_bus.wb_d1;
            r_wb_ready <= !io_bus.wb_we2;
         end else if (io_bus.wb_we2) begin
            r_state    <= ST_W2;
            r_rf_we    <= 1'b1;
            r_rf_wa    <= io_bus.wb_ws2;
            r_rf_wd    <= io_bus.wb_d2;
            r_wb_ready <= 1'b1;
         end else begin
            r_state    <= ST_IDLE;
            r_rf_we    <= 1'b0;
            r_wb_ready <= 1'b1;
         end
      end else begin
         r_state    <= ST_IDLE;
         r_rf_we    <= 1'b0;
         r_wb_ready <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomised scoreboard bench for rf_wb_sched.
// Reference: pending-write counts per register and a timed write list.
module tb_rf_wb_sched;
   import rf_wb_sched_pkg::*;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            due;
   } wr_t;

   typedef struct {
      logic [AW-1:0] ws1;
      logic          we1;
      logic [AW-1:0] ws2;
      logic          we2;
   } pr_t;

   localparam int LIMIT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  pend [NREGS];
   wr_t exp_q [$];
   pr_t iss_q [$];
   bit  wb_acc = 1'b0;
   bit  presenting = 1'b0;

   wr_t w;
   bit  has_w, exp_wbr, exp_issr, haz, ovf;
   int  eff [NREGS];
   int  add1, add2;

   always #5 clk = ~clk;

   rf_wb_sched_if bus ();

   rf_wb_sched dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(99) < p;
   endfunction

   // Monitor: compare DUT outputs with the reference, then advance it.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_iss_ready", 32'(bus.iss_ready), 32'(0));
         chk("rst_rf_we", 32'(bus.rf_we), 32'(0));
         chk("rst_rf_wa", 32'(bus.rf_wa), 32'(0));
         chk("rst_rf_wd", bus.rf_wd, 32'(0));
         exp_q.delete();
         foreach (pend[i]) pend[i] = 0;
         wb_acc = 1'b0;
      end else begin
         cyc++;
         has_w = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            has_w = 1'b1;
            w = exp_q.pop_front();
         end
         chk("rf_we", 32'(bus.rf_we), 32'(has_w));
         if (has_w && bus.rf_we) begin
            chk("rf_wa", 32'(bus.rf_wa), 32'(w.a));
            chk("rf_wd", bus.rf_wd, w.d);
         end

         exp_wbr = 1'b1;
         foreach (exp_q[i])
            if (exp_q[i].due > cyc) exp_wbr = 1'b0;
         chk("wb_ready", 32'(bus.wb_ready), 32'(exp_wbr));

         foreach (eff[i]) eff[i] = pend[i];
`ifdef RF_WB_BYPASS_EN
         if (has_w) eff[w.a] -= 1;
`endif
         haz = 1'b0;
         for (int k = 0; k < 3; k++)
            if (bus.iss_rs_use[k] && eff[bus.iss_rs[4*k +: 4]] != 0)
               haz = 1'b1;
         add1 = (bus.iss_we2 && bus.iss_ws2 == bus.iss_ws1) ? 2 : 1;
         add2 = (bus.iss_we1 && bus.iss_ws1 == bus.iss_ws2) ? 2 : 1;
         ovf = (bus.iss_we1 && pend[bus.iss_ws1] + add1 > LIMIT)
            || (bus.iss_we2 && pend[bus.iss_ws2] + add2 > LIMIT);
         exp_issr = !haz && !ovf;
         chk("iss_ready", 32'(bus.iss_ready), 32'(exp_issr));

         if (has_w) pend[w.a]--;
         if (bus.iss_valid && exp_issr) begin
            if (bus.iss_we1) pend[bus.iss_ws1]++;
            if (bus.iss_we2) pend[bus.iss_ws2]++;
            iss_q.push_back('{bus.iss_ws1, bus.iss_we1,
                              bus.iss_ws2, bus.iss_we2});
         end
         if (bus.wb_valid && exp_wbr) begin
            if (bus.wb_we1)
               exp_q.push_back('{bus.wb_ws1, bus.wb_d1, cyc + 1});
            if (bus.wb_we2)
               exp_q.push_back('{bus.wb_ws2, bus.wb_d2,
                                 bus.wb_we1 ? cyc + 2 : cyc + 1});
            wb_acc = 1'b1;
         end
      end
   end

   // One cycle of stimulus for the given phase.
   task automatic drive(input int ph);
      pr_t p;
      int  mx;
      if (wb_acc) begin
         presenting = 1'b0;
         wb_acc = 1'b0;
      end
      if (!presenting && iss_q.size() > 0 &&
          pct(ph == 0 ? 70 : ph == 2 ? 20 : ph == 3 ? 80 : 100)) begin
         p = iss_q.pop_front();
         bus.wb_ws1 = p.ws1;
         bus.wb_we1 = p.we1;
         bus.wb_ws2 = p.ws2;
         bus.wb_we2 = p.we2;
         bus.wb_d1  = $urandom;
         bus.wb_d2  = $urandom;
         presenting = 1'b1;
      end
      bus.wb_valid = presenting;

      mx = (ph == 3) ? 5 : (ph == 0) ? 7 : 15;
      bus.iss_rs = {4'($urandom_range(mx)), 4'($urandom_range(mx)),
                    4'($urandom_range(mx))};
      case (ph)
         0: begin
            bus.iss_valid  = pct(60);
            bus.iss_ws1    = 4'($urandom_range(7));
            bus.iss_ws2    = 4'($urandom_range(7));
            bus.iss_we1    = 1'($urandom_range(1));
            bus.iss_we2    = 1'($urandom_range(1));
            bus.iss_rs_use = 3'($urandom_range(7));
         end
         1: begin
            bus.iss_valid  = 1'b1;
            bus.iss_ws1    = 4'($urandom_range(15));
            bus.iss_ws2    = 4'd0;
            bus.iss_we1    = 1'b1;
            bus.iss_we2    = 1'b0;
            bus.iss_rs_use = 3'd0;
         end
         2: begin
            bus.iss_valid  = pct(80);
            bus.iss_ws1    = pct(80) ? 4'd1 : 4'($urandom_range(15));
            bus.iss_ws2    = 4'd1;
            bus.iss_we1    = 1'b1;
            bus.iss_we2    = pct(30);
            bus.iss_rs_use = 3'd0;
         end
         3: begin
            bus.iss_valid  = pct(60);
            bus.iss_ws1    = 4'($urandom_range(5));
            bus.iss_ws2    = 4'($urandom_range(5));
            bus.iss_we1    = 1'b1;
            bus.iss_we2    = 1'b1;
            bus.iss_rs_use = 3'($urandom_range(7));
         end
         default: begin
            bus.iss_valid  = 1'b0;
            bus.iss_rs_use = 3'b111;
         end
      endcase
   endtask

   task automatic run(input int ph, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drive(ph);
      end
   endtask

   initial begin
      bit found;
      bus.iss_valid = 1'b0; bus.iss_rs = '0; bus.iss_rs_use = '0;
      bus.iss_ws1 = '0; bus.iss_we1 = 1'b0;
      bus.iss_ws2 = '0; bus.iss_we2 = 1'b0;
      bus.wb_valid = 1'b0; bus.wb_ws1 = '0; bus.wb_we1 = 1'b0;
      bus.wb_d1 = '0; bus.wb_ws2 = '0; bus.wb_we2 = 1'b0; bus.wb_d2 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run(0, 400);
      run(1, 200);
      run(2, 200);
      run(3, 300);

      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1;
         foreach (exp_q[j])
            if (exp_q[j].due == cyc + 2) found = 1'b1;
         if (!found) drive(3);
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL midpair_search: got none expected a two-write pair");
      end else begin
         rst = 1'b1;
         iss_q.delete();
         presenting = 1'b0;
         wb_acc = 1'b0;
         bus.iss_valid = 1'b0;
         bus.wb_valid = 1'b0;
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         bus.iss_rs_use = 3'b111;
      end

      run(4, 5);
      run(0, 300);
      run(4, 60);
      chk("drain", 32'(exp_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
